// File: rtl/execute_if.sv
// Execute-stage bundle: decode->execute inputs, execute->memory outputs, stall/flush.
`ifndef ADDR_SIZE
`define ADDR_SIZE 31
`endif
`ifndef EX_WIDTH
`define EX_WIDTH 3
`endif
`ifndef REG_DATA_SIZE
`define REG_DATA_SIZE 31
`endif
`ifndef REG_ADDR_SIZE
`define REG_ADDR_SIZE 4
`endif
`ifndef EX_INSTR_MISALIGNED
`define EX_INSTR_MISALIGNED 4'd0
`endif
`ifndef EX_ILLEGAL_INSTR
`define EX_ILLEGAL_INSTR 4'd2
`endif

interface execute_if #(parameter int XLEN = 32);
  logic [`ADDR_SIZE:0]     PC_in;
  logic [`EX_WIDTH:0]      exception_in;
  logic                    exception_in_valid;
  logic                    pipeline_in_valid;
  logic [4:0]              opcode;
  logic [2:0]              funct;
  logic                    variant;
  logic [XLEN-1:0]         op1;
  logic [XLEN-1:0]         op2;
  logic [`REG_ADDR_SIZE:0] rd_addr;
  logic [XLEN-1:0]         offset;
  logic                    nop_instr;
  logic                    stall;
  logic                    flush;

  logic [`ADDR_SIZE:0]     PC_out;
  logic [`EX_WIDTH:0]      exception_out;
  logic                    exception_out_valid;
  logic                    pipeline_out_valid;
  logic [4:0]              opcode_out;
  logic [2:0]              funct_out;
  logic [XLEN-1:0]         result;
  logic [XLEN-1:0]         mem_addr;
  logic [XLEN-1:0]         store_data;
  logic [`REG_ADDR_SIZE:0] rd_addr_out;
  logic                    rd_write_en;
  logic                    branch_taken;
  logic [`ADDR_SIZE:0]     branch_target;
  logic                    stall_out;

  modport master (
    output PC_in, exception_in, exception_in_valid, pipeline_in_valid, opcode, funct,
           variant, op1, op2, rd_addr, offset, nop_instr, stall, flush,
    input  PC_out, exception_out, exception_out_valid, pipeline_out_valid, opcode_out,
           funct_out, result, mem_addr, store_data, rd_addr_out, rd_write_en,
           branch_taken, branch_target, stall_out
  );

  modport slave (
    input  PC_in, exception_in, exception_in_valid, pipeline_in_valid, opcode, funct,
           variant, op1, op2, rd_addr, offset, nop_instr, stall, flush,
    output PC_out, exception_out, exception_out_valid, pipeline_out_valid, opcode_out,
           funct_out, result, mem_addr, store_data, rd_addr_out, rd_write_en,
           branch_taken, branch_target, stall_out
  );
endinterface

// File: rtl/execute.sv
// Execute stage: ALU, branch/jump resolution, load/store address generation.
// Define SERIAL_SHIFT_EN for an iterative 1-bit/cycle shifter instead of the barrel shifter.
`ifndef ADDR_SIZE
`define ADDR_SIZE 31
`endif
`ifndef EX_WIDTH
`define EX_WIDTH 3
`endif
`ifndef REG_ADDR_SIZE
`define REG_ADDR_SIZE 4
`endif
`ifndef EX_INSTR_MISALIGNED
`define EX_INSTR_MISALIGNED 4'd0
`endif
`ifndef EX_ILLEGAL_INSTR
`define EX_ILLEGAL_INSTR 4'd2
`endif

module execute #(
  parameter int                  XLEN     = 32,
  parameter logic [`ADDR_SIZE:0] RESET_PC = '0
) (
  input logic      clk,
  input logic      reset,
  execute_if.slave bus
);
  localparam int AW = `ADDR_SIZE + 1;
  localparam logic [4:0] OP_LOAD   = 5'b00000, OP_STORE = 5'b01000, OP_BRANCH = 5'b11000,
                         OP_JALR   = 5'b11001, OP_JAL   = 5'b11011, OP_IMM    = 5'b00100,
                         OP_ARITH  = 5'b01100, OP_LUI   = 5'b01101, OP_AUIPC  = 5'b00101;

  logic [XLEN-1:0]    alu, n_result, n_mem_addr, n_store_data;
  logic [AW-1:0]      n_target;
  logic               n_taken, n_we, n_excv, br_cond;
  logic [`EX_WIDTH:0] n_exc;
  logic [4:0]         shamt;
  logic               is_alu;

  assign shamt  = bus.op2[4:0];
  assign is_alu = (bus.opcode == OP_ARITH) || (bus.opcode == OP_IMM);

  always_comb begin
    alu = '0;
    case (bus.funct)
      3'd0: alu = (bus.variant && bus.opcode == OP_ARITH) ? bus.op1 - bus.op2 : bus.op1 + bus.op2;
`ifndef SERIAL_SHIFT_EN
      3'd1: alu = bus.op1 << shamt;
      3'd5: alu = bus.variant ? $unsigned($signed(bus.op1) >>> shamt) : bus.op1 >> shamt;
`endif
      3'd2: alu = {{(XLEN-1){1'b0}}, $signed(bus.op1) < $signed(bus.op2)};
      3'd3: alu = {{(XLEN-1){1'b0}}, bus.op1 < bus.op2};
      3'd4: alu = bus.op1 ^ bus.op2;
      3'd6: alu = bus.op1 | bus.op2;
      3'd7: alu = bus.op1 & bus.op2;
      default: alu = '0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (bus.funct)
      3'd0: br_cond = (bus.op1 == bus.op2);
      3'd1: br_cond = (bus.op1 != bus.op2);
      3'd4: br_cond = ($signed(bus.op1) <  $signed(bus.op2));
      3'd5: br_cond = ($signed(bus.op1) >= $signed(bus.op2));
      3'd6: br_cond = (bus.op1 <  bus.op2);
      3'd7: br_cond = (bus.op1 >= bus.op2);
      default: br_cond = 1'b0;
    endcase
  end

  // Single-cycle result bundle derived straight from the decode inputs.
  always_comb begin
    n_result     = '0;
    n_mem_addr   = '0;
    n_store_data = '0;
    n_target     = '0;
    n_taken      = 1'b0;
    n_we         = 1'b0;
    n_excv       = 1'b0;
    n_exc        = '0;
    if (bus.exception_in_valid) begin
      n_excv = 1'b1;
      n_exc  = bus.exception_in;
    end else if (!bus.nop_instr) begin
      case (bus.opcode)
        OP_ARITH, OP_IMM: begin n_result = alu; n_we = 1'b1; end
        OP_LUI:   begin n_result = bus.op2; n_we = 1'b1; end
        OP_AUIPC: begin n_result = XLEN'(bus.PC_in + AW'(bus.op2)); n_we = 1'b1; end
        OP_JAL: begin
          n_target = bus.PC_in + AW'(bus.op2);
          n_taken  = 1'b1;
          n_result = XLEN'(bus.PC_in + AW'(4));
          n_we     = 1'b1;
        end
        OP_JALR: begin
          n_target = AW'(bus.op1 + bus.op2) & ~AW'(1);
          n_taken  = 1'b1;
          n_result = XLEN'(bus.PC_in + AW'(4));
          n_we     = 1'b1;
        end
        OP_BRANCH: begin
          if (bus.funct == 3'd2 || bus.funct == 3'd3) begin
            n_excv = 1'b1;
            n_exc  = `EX_ILLEGAL_INSTR;
          end else begin
            n_target = bus.PC_in + AW'(bus.offset);
            n_taken  = br_cond;
          end
        end
        OP_LOAD:  begin n_mem_addr = bus.op1 + bus.op2; n_we = 1'b1; end
        OP_STORE: begin n_mem_addr = bus.op1 + bus.offset; n_store_data = bus.op2; end
        default: ;
      endcase
      if (n_taken && n_target[1:0] != 2'b00) begin
        n_taken = 1'b0;
        n_we    = 1'b0;
        n_excv  = 1'b1;
        n_exc   = `EX_INSTR_MISALIGNED;
      end
    end
    if (bus.rd_addr == '0) n_we = 1'b0;
  end

  logic                    load_out, w_taken, w_we, w_excv;
  logic [XLEN-1:0]         w_result, w_mem_addr, w_store_data;
  logic [AW-1:0]           w_pc, w_target;
  logic [4:0]              w_op;
  logic [2:0]              w_funct;
  logic [`REG_ADDR_SIZE:0] w_rd;
  logic [`EX_WIDTH:0]      w_exc;

`ifdef SERIAL_SHIFT_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  state_t                  state, state_n;
  logic [XLEN-1:0]         sh_val, sh_next;
  logic [4:0]              sh_cnt;
  logic                    sh_right, sh_arith, is_shift, cap;
  logic [AW-1:0]           sh_pc;
  logic [4:0]              sh_op;
  logic [2:0]              sh_funct;
  logic [`REG_ADDR_SIZE:0] sh_rd;

  assign is_shift = is_alu && (bus.funct[1:0] == 2'b01) && !bus.exception_in_valid && !bus.nop_instr;
  assign cap      = (state == S_IDLE) && bus.pipeline_in_valid && is_shift;
  assign sh_next  = sh_right ? {sh_arith & sh_val[XLEN-1], sh_val[XLEN-1:1]}
                             : {sh_val[XLEN-2:0], 1'b0};
  // Decode keeps presenting the shift until DONE, so DONE must ignore its inputs.
  assign bus.stall_out = bus.stall || (state == S_SHIFT) || cap;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (bus.flush) state_n = S_IDLE;
    else if (!bus.stall) begin
      case (state)
        S_IDLE:  if (cap) state_n = (shamt == 5'd0) ? S_DONE : S_SHIFT;
        S_SHIFT: if (sh_cnt == 5'd1) state_n = S_DONE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!bus.stall) begin
      if (cap) begin
        sh_val   <= bus.op1;
        sh_cnt   <= shamt;
        sh_right <= bus.funct[2];
        sh_arith <= bus.variant;
        sh_pc    <= bus.PC_in;
        sh_op    <= bus.opcode;
        sh_funct <= bus.funct;
        sh_rd    <= bus.rd_addr;
      end else if (state == S_SHIFT) begin
        sh_val <= sh_next;
        sh_cnt <= sh_cnt - 5'd1;
      end
    end
  end
`else
  assign bus.stall_out = bus.stall;
`endif

  always_comb begin
    load_out     = bus.pipeline_in_valid;
    w_pc         = bus.PC_in;
    w_op         = bus.opcode;
    w_funct      = bus.funct;
    w_rd         = bus.rd_addr;
    w_result     = n_result;
    w_mem_addr   = n_mem_addr;
    w_store_data = n_store_data;
    w_target     = n_target;
    w_taken      = n_taken;
    w_we         = n_we;
    w_excv       = n_excv;
    w_exc        = n_exc;
`ifdef SERIAL_SHIFT_EN
    if (state == S_DONE) begin
      load_out     = 1'b1;
      w_pc         = sh_pc;
      w_op         = sh_op;
      w_funct      = sh_funct;
      w_rd         = sh_rd;
      w_result     = sh_val;
      w_mem_addr   = '0;
      w_store_data = '0;
      w_target     = '0;
      w_taken      = 1'b0;
      w_we         = (sh_rd != '0);
      w_excv       = 1'b0;
      w_exc        = '0;
    end else if (state == S_SHIFT || is_shift) begin
      load_out = 1'b0;
    end
`else
    if (!is_alu) load_out = bus.pipeline_in_valid;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.PC_out              <= RESET_PC;
      bus.exception_out       <= '0;
      bus.exception_out_valid <= 1'b0;
      bus.pipeline_out_valid  <= 1'b0;
      bus.opcode_out          <= '0;
      bus.funct_out           <= '0;
      bus.result              <= '0;
      bus.mem_addr            <= '0;
      bus.store_data          <= '0;
      bus.rd_addr_out         <= '0;
      bus.rd_write_en         <= 1'b0;
      bus.branch_taken        <= 1'b0;
      bus.branch_target       <= '0;
    end else if (bus.flush) begin
      bus.pipeline_out_valid <= 1'b0;
      bus.branch_taken       <= 1'b0;
    end else if (bus.stall) begin
      bus.branch_taken <= 1'b0;
    end else if (load_out) begin
      bus.PC_out              <= w_pc;
      bus.exception_out       <= w_exc;
      bus.exception_out_valid <= w_excv;
      bus.pipeline_out_valid  <= 1'b1;
      bus.opcode_out          <= w_op;
      bus.funct_out           <= w_funct;
      bus.result              <= w_result;
      bus.mem_addr            <= w_mem_addr;
      bus.store_data          <= w_store_data;
      bus.rd_addr_out         <= w_rd;
      bus.rd_write_en         <= w_we;
      bus.branch_taken        <= w_taken;
      bus.branch_target       <= w_target;
    end else begin
      bus.pipeline_out_valid <= 1'b0;
      bus.branch_taken       <= 1'b0;
    end
  end
endmodule

// File: tb/tb_execute.sv
// Directed + random bench for execute against a spec-level reference model.
`ifndef EX_INSTR_MISALIGNED
`define EX_INSTR_MISALIGNED 4'd0
`endif
`ifndef EX_ILLEGAL_INSTR
`define EX_ILLEGAL_INSTR 4'd2
`endif

module tb_execute;
  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [4:0] LOAD = 5'b00000, STORE = 5'b01000, BRANCH = 5'b11000, JALR = 5'b11001,
                         JAL = 5'b11011, IMM = 5'b00100, ARITH = 5'b01100, LUI = 5'b01101,
                         AUIPC = 5'b00101;

  typedef struct {
    logic [31:0] pc, op1, op2, off;
    logic [4:0]  opc;
    logic [2:0]  f;
    logic        v;
    logic [4:0]  rd;
    logic        nop, xv;
    logic [3:0]  xc;
  } ins_t;

  typedef struct {
    logic [31:0] res, maddr, sd, tgt;
    bit          chk_res, chk_maddr, chk_sd;
    logic        taken, we, excv;
    logic [3:0]  exc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  execute_if #(.XLEN(32)) bus();
  execute #(.XLEN(32), .RESET_PC(RST_PC)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic ins_t mk(input logic [4:0] opc, input logic [2:0] f, input logic v,
                              input logic [31:0] op1, input logic [31:0] op2,
                              input logic [31:0] off, input logic [31:0] pc, input logic [4:0] rd);
    ins_t i;
    i.opc = opc; i.f = f; i.v = v; i.op1 = op1; i.op2 = op2; i.off = off; i.pc = pc; i.rd = rd;
    i.nop = 1'b0; i.xv = 1'b0; i.xc = 4'd0;
    return i;
  endfunction

  // Reference: instruction semantics computed with plain integer arithmetic.
  function automatic exp_t model(input ins_t i);
    exp_t e;
    longint p, s;
    int unsigned sh;
    bit cond;
    e = '{default: '0};
    if (i.xv) begin e.excv = 1'b1; e.exc = i.xc; return e; end
    if (i.nop) return e;
    sh = i.op2 % 32;
    p  = longint'(1) << sh;
    case (i.opc)
      ARITH, IMM: begin
        e.chk_res = 1; e.we = 1'b1;
        case (i.f)
          3'd0: e.res = (i.opc == ARITH && i.v) ? i.op1 - i.op2 : i.op1 + i.op2;
          3'd1: e.res = 32'(longint'(i.op1) * p);
          3'd2: e.res = (int'(i.op1) < int'(i.op2)) ? 32'd1 : 32'd0;
          3'd3: e.res = (i.op1 < i.op2) ? 32'd1 : 32'd0;
          3'd4: e.res = i.op1 ^ i.op2;
          3'd5: begin
            if (i.v) begin
              s = longint'(int'(i.op1));
              e.res = 32'((s < 0) ? (s - (p - 1)) / p : s / p);
            end else e.res = 32'(longint'(i.op1) / p);
          end
          3'd6: e.res = i.op1 | i.op2;
          default: e.res = i.op1 & i.op2;
        endcase
      end
      LUI:   begin e.chk_res = 1; e.we = 1'b1; e.res = i.op2; end
      AUIPC: begin e.chk_res = 1; e.we = 1'b1; e.res = i.pc + i.op2; end
      JAL:   begin e.chk_res = 1; e.we = 1'b1; e.res = i.pc + 4; e.taken = 1'b1; e.tgt = i.pc + i.op2; end
      JALR:  begin e.chk_res = 1; e.we = 1'b1; e.res = i.pc + 4; e.taken = 1'b1; e.tgt = (i.op1 + i.op2) & ~32'd1; end
      BRANCH: begin
        cond = 0;
        case (i.f)
          3'd0: cond = (i.op1 == i.op2);
          3'd1: cond = (i.op1 != i.op2);
          3'd4: cond = (int'(i.op1) < int'(i.op2));
          3'd5: cond = (int'(i.op1) >= int'(i.op2));
          3'd6: cond = (i.op1 < i.op2);
          3'd7: cond = (i.op1 >= i.op2);
          default: begin e.excv = 1'b1; e.exc = `EX_ILLEGAL_INSTR; end
        endcase
        e.taken = cond; e.tgt = i.pc + i.off;
      end
      LOAD:  begin e.we = 1'b1; e.chk_maddr = 1; e.maddr = i.op1 + i.op2; end
      STORE: begin e.chk_maddr = 1; e.maddr = i.op1 + i.off; e.chk_sd = 1; e.sd = i.op2; end
      default: ;
    endcase
    if (e.taken && e.tgt[1:0] != 2'b00) begin
      e.taken = 1'b0; e.we = 1'b0; e.excv = 1'b1; e.exc = `EX_INSTR_MISALIGNED;
    end
    if (i.rd == 5'd0) e.we = 1'b0;
    return e;
  endfunction

  task automatic drive(input ins_t i);
    bus.PC_in = i.pc; bus.opcode = i.opc; bus.funct = i.f; bus.variant = i.v;
    bus.op1 = i.op1; bus.op2 = i.op2; bus.offset = i.off; bus.rd_addr = i.rd;
    bus.nop_instr = i.nop; bus.exception_in_valid = i.xv; bus.exception_in = i.xc;
    bus.pipeline_in_valid = 1'b1;
  endtask

  // Presents one instruction like decode would (held while stall_out), then checks the result.
  task automatic run(input string tag, input ins_t i);
    exp_t e;
    int   edges, stalls, exp_lat, exp_stalls;
    bit   presenting, accept_now, got;
    e = model(i);
    exp_lat = 1; exp_stalls = 0;
`ifdef SERIAL_SHIFT_EN
    if (!i.xv && !i.nop && (i.opc == ARITH || i.opc == IMM) && i.f[1:0] == 2'b01) begin
      exp_lat = (i.op2 % 32) + 2; exp_stalls = (i.op2 % 32) + 1;
    end
`endif
    drive(i);
    presenting = 1; edges = 0; stalls = 0; got = 0;
    while (!got && edges < 80) begin
      #1;
      accept_now = presenting && !bus.stall_out;
      if (presenting && bus.stall_out) stalls++;
      @(negedge clk);
      edges++;
      if (accept_now) begin presenting = 0; bus.pipeline_in_valid = 1'b0; end
      if (bus.pipeline_out_valid) got = 1;
    end
    bus.pipeline_in_valid = 1'b0;
    chk({tag, ".valid"}, got, 1);
    if (got) begin
      chk({tag, ".lat"}, edges, exp_lat);
      chk({tag, ".stall_out"}, stalls, exp_stalls);
      chk({tag, ".pc"}, bus.PC_out, i.pc);
      chk({tag, ".rd"}, bus.rd_addr_out, i.rd);
      chk({tag, ".opc"}, bus.opcode_out, i.opc);
      chk({tag, ".funct"}, bus.funct_out, i.f);
      chk({tag, ".we"}, bus.rd_write_en, e.we);
      chk({tag, ".taken"}, bus.branch_taken, e.taken);
      chk({tag, ".excv"}, bus.exception_out_valid, e.excv);
      if (e.excv)      chk({tag, ".exc"}, bus.exception_out, e.exc);
      if (e.taken)     chk({tag, ".tgt"}, bus.branch_target, e.tgt);
      if (e.chk_res)   chk({tag, ".res"}, bus.result, e.res);
      if (e.chk_maddr) chk({tag, ".maddr"}, bus.mem_addr, e.maddr);
      if (e.chk_sd)    chk({tag, ".sdata"}, bus.store_data, e.sd);
    end
    @(negedge clk);
    chk({tag, ".idle_valid"}, bus.pipeline_out_valid, 0);
    chk({tag, ".idle_taken"}, bus.branch_taken, 0);
  endtask

  initial begin
    ins_t i;
    int pulses;
    logic [4:0] opcs [9];
    opcs = '{ARITH, IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE};
    bus.stall = 1'b0; bus.flush = 1'b0; bus.pipeline_in_valid = 1'b0;
    drive(mk(ARITH, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0));
    bus.pipeline_in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.valid", bus.pipeline_out_valid, 0);
    chk("rst.taken", bus.branch_taken, 0);
    chk("rst.stall_out", bus.stall_out, 0);
    chk("rst.pc", bus.PC_out, RST_PC);
    chk("rst.result", bus.result, 0);
    chk("rst.we", bus.rd_write_en, 0);
    reset = 1'b0;
    @(negedge clk);

    run("add",  mk(ARITH, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 32'h10, 5'd3));
    run("sub",  mk(ARITH, 3'd0, 1'b1, 32'd3, 32'd5, 32'd0, 32'h14, 5'd4));
    run("slt",  mk(ARITH, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h18, 5'd5));
    run("sltu", mk(ARITH, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h1C, 5'd6));
    run("beq",  mk(BRANCH, 3'd0, 1'b0, 32'd9, 32'd9, 32'h20, 32'h100, 5'd0));
    run("bne",  mk(BRANCH, 3'd1, 1'b0, 32'd9, 32'd9, 32'h20, 32'h100, 5'd0));
    run("jal",  mk(JAL, 3'd0, 1'b0, 32'd0, 32'd8, 32'd0, 32'h40, 5'd1));
    run("jalr", mk(JALR, 3'd0, 1'b0, 32'h103, 32'd0, 32'd0, 32'h50, 5'd1));
    run("sra",  mk(ARITH, 3'd5, 1'b1, 32'h8000_0000, 32'd4, 32'd0, 32'h60, 5'd7));
    run("slli0", mk(IMM, 3'd1, 1'b0, 32'h1234_5678, 32'd0, 32'd0, 32'h64, 5'd8));
    run("bill", mk(BRANCH, 3'd2, 1'b0, 32'd1, 32'd1, 32'h8, 32'h70, 5'd0));
    i = mk(JAL, 3'd0, 1'b0, 32'd0, 32'd8, 32'd0, 32'h80, 5'd2);
    i.xv = 1'b1; i.xc = 4'd5;
    run("exc_pass", i);
    i = mk(ARITH, 3'd0, 1'b0, 32'd1, 32'd2, 32'd0, 32'h84, 5'd2);
    i.nop = 1'b1;
    run("nop", i);

    // Downstream stall right after a taken branch: outputs frozen, redirect fires once.
    drive(mk(BRANCH, 3'd0, 1'b0, 32'd9, 32'd9, 32'h20, 32'h200, 5'd0));
    @(negedge clk);
    bus.pipeline_in_valid = 1'b0;
    bus.stall = 1'b1;
    pulses = int'(bus.branch_taken);
    chk("stl.tgt0", bus.branch_target, 32'h220);
    repeat (3) begin
      @(negedge clk);
      pulses += int'(bus.branch_taken);
      chk("stl.valid", bus.pipeline_out_valid, 1);
      chk("stl.tgt", bus.branch_target, 32'h220);
      chk("stl.pc", bus.PC_out, 32'h200);
      chk("stl.stall_out", bus.stall_out, 1);
    end
    bus.stall = 1'b0;
    @(negedge clk);
    pulses += int'(bus.branch_taken);
    chk("stl.after_valid", bus.pipeline_out_valid, 0);
    chk("stl.pulses", pulses, 1);

`ifdef SERIAL_SHIFT_EN
    drive(mk(ARITH, 3'd5, 1'b1, 32'h8000_0000, 32'd4, 32'd0, 32'h300, 5'd9));
    @(negedge clk);
    chk("fl.busy", bus.stall_out, 1);
    @(negedge clk);
    bus.flush = 1'b1;
    bus.pipeline_in_valid = 1'b0;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("fl.stall_out", bus.stall_out, 0);
    repeat (6) begin
      @(negedge clk);
      chk("fl.valid", bus.pipeline_out_valid, 0);
    end
`else
    drive(mk(ARITH, 3'd5, 1'b1, 32'h8000_0000, 32'd4, 32'd0, 32'h300, 5'd9));
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.pipeline_in_valid = 1'b0;
    chk("fl.valid", bus.pipeline_out_valid, 0);
    @(negedge clk);
    chk("fl.valid2", bus.pipeline_out_valid, 0);
`endif
    run("post_flush", mk(ARITH, 3'd0, 1'b0, 32'd100, 32'd23, 32'd0, 32'h310, 5'd10));

    for (int n = 0; n < 80; n++) begin
      i = mk(opcs[$urandom_range(0, 8)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             $urandom(), $urandom(), $urandom(), $urandom() & 32'hFFFF_FFFC,
             5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) i.op2 = i.op1;
      if ($urandom_range(0, 3) != 0) begin
        i.off = i.off & 32'hFFFF_FFFC;
        if (i.opc == JAL) i.op2 = i.op2 & 32'hFFFF_FFFC;
      end
      if ((i.opc == ARITH || i.opc == IMM) && i.f[1:0] == 2'b01) i.op2 = i.op2 & 32'h0000_001F;
      i.nop = ($urandom_range(0, 9) == 0);
      i.xv  = ($urandom_range(0, 9) == 0);
      i.xc  = 4'($urandom_range(0, 15));
      run("rnd", i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/execute.md
Name: execute

Overview:
- Execute stage of the 5-stage integer pipeline; the consumer of the decode stage's registered output bundle (PC, opcode, funct, variant, op1, op2, offset, rd_addr, nop_instr, exception).
- Performs ALU operations, branch/jump resolution, and load/store address generation.
- Registers the result bundle for the memory stage.
- Raises a one-cycle redirect (branch_taken + branch_target) that top level routes to fetch and to the decode flush input.

Parameters:
- XLEN, 32, datapath width; must equal `REG_DATA_SIZE+1.
- RESET_PC, 32'h0, value of PC_out after reset.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- PC_in  input  `ADDR_SIZE+1  PC of incoming instruction
- exception_in  input  `EX_WIDTH+1  upstream exception code
- exception_in_valid  input  1  upstream exception present
- pipeline_in_valid  input  1  input bundle valid
- opcode  input  5  instr[6:2]
- funct  input  3  f3
- variant  input  1  f7[5]
- op1  input  XLEN  rs1 data
- op2  input  XLEN  rs2 data or immediate
- rd_addr  input  `REG_ADDR_SIZE+1  destination register
- offset  input  XLEN  branch/store immediate
- nop_instr  input  1  bubble/NOP/FENCE marker
- PC_out  output  `ADDR_SIZE+1  registered PC
- exception_out  output  `EX_WIDTH+1  exception code
- exception_out_valid  output  1  exception present
- pipeline_out_valid  output  1  output bundle valid
- opcode_out  output  5  passed through for memory stage
- funct_out  output  3  passed through (load/store size)
- result  output  XLEN  ALU result / link address
- mem_addr  output  XLEN  effective load/store address
- store_data  output  XLEN  op2 for stores
- rd_addr_out  output  `REG_ADDR_SIZE+1  destination
- rd_write_en  output  1  writeback required (ARITH, IMM_ARITH, LUI, AUIPC, JAL, JALR, LOAD; 0 when rd==0, nop or exception)
- branch_taken  output  1  one-cycle redirect pulse
- branch_target  output  `ADDR_SIZE+1  redirect PC
- stall  input  1  downstream stall
- flush  input  1  kill the stage (trap)
- stall_out  output  1  stall request to decode/fetch

Behaviour:
- Reset: all outputs zero except PC_out=RESET_PC.
  - pipeline_out_valid=0, branch_taken=0, stall_out=0.
  - Any in-progress shift is aborted.
- Priority each clock: reset|flush > stall > busy shift > pipeline_in_valid.
- reset|flush:
  - pipeline_out_valid<=0, branch_taken<=0, shift FSM -> IDLE.
  - Other outputs are held.
- stall (downstream): all output registers hold; branch_taken<=0 so the redirect never repeats; stall_out=1 combinationally.
- Latency: 1 cycle from pipeline_in_valid to registered outputs (single-cycle ops).
- ALU for ARITH/IMM_ARITH by funct:
  - 0: ADD, or SUB when variant=1 and opcode=ARITH.
  - 1: SLL.
  - 2: SLT (signed).
  - 3: SLTU.
  - 4: XOR.
  - 5: SRL, or SRA when variant=1.
  - 6: OR.
  - 7: AND.
  - Shift amount = op2[4:0]; all arithmetic mod 2^XLEN.
- LUI: result=op2. AUIPC: result=PC_in+op2.
- JAL: target=PC_in+op2; result=PC_in+4.
- JALR: target=(op1+op2)&~1; result=PC_in+4.
- BRANCH, funct 0/1/4/5/6/7 = BEQ/BNE/BLT/BGE/BLTU/BGEU:
  - taken -> target=PC_in+offset.
  - funct 2/3 -> EX_ILLEGAL_INSTR.
- LOAD: mem_addr=op1+op2. STORE: mem_addr=op1+offset, store_data=op2.
- Misaligned taken target (target[1:0]!=0):
  - exception_out=`EX_INSTR_MISALIGNED (added to def_params.v), exception_out_valid=1.
  - branch_taken=0, rd_write_en=0.
- Exception pass-through: exception_in_valid=1 passes exception_in unchanged; no redirect, no writeback, no shift.
- nop_instr=1: pipeline_out_valid follows input; rd_write_en=0; branch_taken=0.
- branch_taken is asserted exactly one cycle, coincident with the valid output of the jump/branch.
- Cycles without pipeline_in_valid (and not busy): pipeline_out_valid<=0, branch_taken<=0.

Optional Feature:
- Macro: SERIAL_SHIFT_EN.
- Defined: SLL/SRL/SRA use an iterative 1-bit-per-cycle shifter.
  - FSM states: IDLE -> SHIFT (load op1, count=shamt) -> DONE.
  - shamt=0 goes straight to DONE.
  - stall_out=1 from the capture cycle while in SHIFT.
  - Decode holds its bundle while stall_out=1.
  - Result is valid shamt+1 cycles after capture.
  - Downstream stall freezes the counter.
  - flush/reset abort to IDLE with no output.
- Undefined: single-cycle barrel shifter; FSM absent; stall_out=stall.

Test Plan:
- ADD op1=5 op2=7 rd=3 -> next cycle result=12, rd_write_en=1, pipeline_out_valid=1.
- SUB op1=3 op2=5 -> result=FFFFFFFE. SLT op1=FFFFFFFF op2=1 -> 1. SLTU with the same operands -> 0.
- BEQ op1=op2=9, PC=0x100, offset=0x20 -> branch_taken=1 for exactly one cycle, branch_target=0x120, rd_write_en=0. BNE with the same operands -> branch_taken=0.
- Jumps:
  - JAL PC=0x40 op2=8 -> result=0x44, target=0x48.
  - JALR op1=0x103 op2=0 -> target=0x102 -> EX_INSTR_MISALIGNED valid, branch_taken=0.
- SRA op1=80000000 op2=4:
  - Under SERIAL_SHIFT_EN: stall_out high 5 cycles, result=F8000000.
  - Otherwise: result next cycle.
  - Flush asserted mid-shift -> pipeline_out_valid=0, FSM IDLE.
- Downstream stall for 3 cycles after a taken branch -> outputs held, branch_taken pulses once. exception_in_valid=1 input -> passed through with rd_write_en=0.
